// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity types, checker states and the parity function
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    typedef enum logic [1:0] {
        CHK_IDLE     = 2'b00,
        CHK_ACCUM    = 2'b01,
        CHK_WAIT_PAR = 2'b10
    } chk_state_e;

    // x is the XOR reduction of the data word; the result is the parity bit to send/expect
    function automatic logic par_of(input logic x, input par_typ_e typ);
        case (typ)
            PAR_EVEN: return x;
            PAR_ODD:  return ~x;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/parity_unit_if.sv
// rtl/parity_unit_if.sv - parity unit bus (checker signals under PARITY_CHECK_EN)
interface parity_unit_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  busy;
    logic                  PAR_EN;
    logic [1:0]            PAR_TYP;
    logic                  par_bit;
`ifdef PARITY_CHECK_EN
    logic                  ser_bit;
    logic                  ser_bit_valid;
    logic                  chk_clr;
    logic                  par_err;
    logic                  chk_done;

    modport master (
        output P_DATA, Data_valid, busy, PAR_EN, PAR_TYP, ser_bit, ser_bit_valid, chk_clr,
        input  par_bit, par_err, chk_done
    );
    modport slave (
        input  P_DATA, Data_valid, busy, PAR_EN, PAR_TYP, ser_bit, ser_bit_valid, chk_clr,
        output par_bit, par_err, chk_done
    );
`else
    modport master (
        output P_DATA, Data_valid, busy, PAR_EN, PAR_TYP,
        input  par_bit
    );
    modport slave (
        input  P_DATA, Data_valid, busy, PAR_EN, PAR_TYP,
        output par_bit
    );
`endif
endinterface

// File: rtl/parity_chk.sv
// rtl/parity_chk.sv - bit-serial RX parity checker FSM
module parity_chk
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     ser_bit_i,
    input  logic     ser_bit_valid_i,
    input  logic     chk_clr_i,
    input  logic     par_en_i,
    input  par_typ_e par_typ_i,
    output logic     par_err_o,
    output logic     chk_done_o
);
    localparam int             CW   = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH);

    chk_state_e    state_q, state_d;
    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    par_typ_e      typ_q, typ_d;
    logic          en_q, en_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= CHK_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            typ_q   <= PAR_EVEN;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            typ_q   <= typ_d;
            en_q    <= en_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    logic          eow;
    logic          eow_en;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        typ_d   = typ_q;
        en_d    = en_q;
        err_d   = err_q;
        done_d  = 1'b0;
        eow     = 1'b0;
        eow_en  = en_q;
        cnt_inc = cnt_q + CW'(1);

        if (chk_clr_i) begin
            state_d = CHK_IDLE;
            acc_d   = 1'b0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                CHK_IDLE: if (ser_bit_valid_i) begin
                    acc_d = ser_bit_i;
                    cnt_d = CW'(1);
                    typ_d = par_typ_i;
                    en_d  = par_en_i;
                    // a 1-bit word ends on its first strobe, before the latch settles
                    if (DATA_WIDTH == 1) begin
                        eow    = 1'b1;
                        eow_en = par_en_i;
                    end else begin
                        state_d = CHK_ACCUM;
                    end
                end
                CHK_ACCUM: if (ser_bit_valid_i) begin
                    acc_d = acc_q ^ ser_bit_i;
                    cnt_d = cnt_inc;
                    eow   = (cnt_inc == LAST);
                end
                CHK_WAIT_PAR: if (ser_bit_valid_i) begin
                    err_d   = (ser_bit_i != par_of(acc_q, typ_q));
                    done_d  = 1'b1;
                    state_d = CHK_IDLE;
                end
                default: state_d = CHK_IDLE;
            endcase

            if (eow) begin
                if (eow_en) begin
                    state_d = CHK_WAIT_PAR;
                end else begin
                    state_d = CHK_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
        end
    end

    always_comb begin
        par_err_o  = err_q;
        chk_done_o = done_q;
    end

endmodule

// File: rtl/parity_unit.sv
// rtl/parity_unit.sv - UART parity generator; bit-serial checker when PARITY_CHECK_EN is defined
module parity_unit
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    parity_unit_if.slave  bus
);
    logic par_bit_q, par_bit_d;

    // PAR_EN does not gate the generator; the serializer decides whether to send the slot
    always_comb begin
        par_bit_d = par_bit_q;
        if (bus.Data_valid && !bus.busy) begin
            par_bit_d = par_of(^bus.P_DATA[DATA_WIDTH-1:0], par_typ_e'(bus.PAR_TYP));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) par_bit_q <= 1'b0;
        else      par_bit_q <= par_bit_d;
    end

    assign bus.par_bit = par_bit_q;

`ifdef PARITY_CHECK_EN
    parity_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .CLK             (CLK),
        .RST             (RST),
        .ser_bit_i       (bus.ser_bit),
        .ser_bit_valid_i (bus.ser_bit_valid),
        .chk_clr_i       (bus.chk_clr),
        .par_en_i        (bus.PAR_EN),
        .par_typ_i       (par_typ_e'(bus.PAR_TYP)),
        .par_err_o       (bus.par_err),
        .chk_done_o      (bus.chk_done)
    );
`else
    logic unused_par_en;
    assign unused_par_en = bus.PAR_EN;
`endif

endmodule

// File: tb/tb_parity_unit.sv
// tb/tb_parity_unit.sv - directed-vector bench for parity_unit (checker part under PARITY_CHECK_EN)
module tb_parity_unit;
    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    parity_unit_if #(.DATA_WIDTH(8)) if8();
    parity_unit_if #(.DATA_WIDTH(1)) if1();

    parity_unit #(.DATA_WIDTH(8)) u_dut8 (.CLK(CLK), .RST(RST), .bus(if8));
    parity_unit #(.DATA_WIDTH(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(if1));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gen(input logic [7:0] d, input logic [1:0] typ, input logic bsy);
        if8.P_DATA     = d;
        if8.PAR_TYP    = typ;
        if8.busy       = bsy;
        if8.Data_valid = 1'b1;
        tick();
        if8.Data_valid = 1'b0;
        if8.busy       = 1'b0;
    endtask

`ifdef PARITY_CHECK_EN
    task automatic strobe8(input logic b);
        if8.ser_bit       = b;
        if8.ser_bit_valid = 1'b1;
        tick();
        if8.ser_bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            strobe8(d[i]);
            repeat (3) tick();
        end
    endtask

    task automatic strobe1(input logic b);
        if1.ser_bit       = b;
        if1.ser_bit_valid = 1'b1;
        tick();
        if1.ser_bit_valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b0;
        if8.P_DATA = '0; if8.Data_valid = 0; if8.busy = 0; if8.PAR_EN = 1; if8.PAR_TYP = 2'b00;
        if1.P_DATA = '0; if1.Data_valid = 0; if1.busy = 0; if1.PAR_EN = 0; if1.PAR_TYP = 2'b00;
`ifdef PARITY_CHECK_EN
        if8.ser_bit = 0; if8.ser_bit_valid = 0; if8.chk_clr = 0;
        if1.ser_bit = 0; if1.ser_bit_valid = 0; if1.chk_clr = 0;
`endif
        repeat (2) tick();
        check("rst_par_bit", 16'(if8.par_bit), 16'h0);
`ifdef PARITY_CHECK_EN
        check("rst_par_err", 16'(if8.par_err), 16'h0);
        check("rst_chk_done", 16'(if8.chk_done), 16'h0);
`endif
        RST = 1'b1;
        tick();

        gen(8'hB3, 2'b00, 1'b0); check("gen_even_b3", 16'(if8.par_bit), 16'h1);
        gen(8'hB3, 2'b01, 1'b0); check("gen_odd_b3", 16'(if8.par_bit), 16'h0);
        gen(8'hB3, 2'b10, 1'b0); check("gen_mark_b3", 16'(if8.par_bit), 16'h1);
        gen(8'hB3, 2'b11, 1'b0); check("gen_space_b3", 16'(if8.par_bit), 16'h0);
        gen(8'h00, 2'b01, 1'b0); check("gen_odd_00", 16'(if8.par_bit), 16'h1);
        gen(8'h01, 2'b00, 1'b0); check("gen_even_01", 16'(if8.par_bit), 16'h1);
        gen(8'h03, 2'b00, 1'b1); check("gen_busy_hold", 16'(if8.par_bit), 16'h1);
        tick();                  check("gen_idle_hold", 16'(if8.par_bit), 16'h1);

        if1.P_DATA = 1'b1; if1.PAR_TYP = 2'b01; if1.Data_valid = 1'b1;
        tick();
        if1.Data_valid = 1'b0;
        check("gen_w1_odd", 16'(if1.par_bit), 16'h0);
        if1.PAR_TYP = 2'b00;

`ifdef PARITY_CHECK_EN
        // odd parity over A5 (four ones): expected parity bit is 1
        if8.PAR_EN = 1'b1; if8.PAR_TYP = 2'b01;
        send_bits(8'hA5, 0, 3);
        if8.PAR_TYP = 2'b00;
        send_bits(8'hA5, 4, 7);
        check("chk_no_early_done", 16'(if8.chk_done), 16'h0);
        strobe8(1'b1);
        check("chk_pass_done", 16'(if8.chk_done), 16'h1);
        check("chk_pass_err", 16'(if8.par_err), 16'h0);
        tick();
        check("chk_done_one_cycle", 16'(if8.chk_done), 16'h0);

        if8.PAR_TYP = 2'b01;
        send_bits(8'hA5, 0, 7);
        strobe8(1'b0);
        check("chk_fail_done", 16'(if8.chk_done), 16'h1);
        check("chk_fail_err", 16'(if8.par_err), 16'h1);
        repeat (2) tick();
        check("chk_err_hold", 16'(if8.par_err), 16'h1);

        send_bits(8'hA5, 0, 3);
        if8.chk_clr = 1'b1; if8.ser_bit = 1'b0; if8.ser_bit_valid = 1'b1;
        tick();
        if8.chk_clr = 1'b0; if8.ser_bit_valid = 1'b0;
        check("clr_no_done", 16'(if8.chk_done), 16'h0);
        check("clr_err", 16'(if8.par_err), 16'h0);
        send_bits(8'h01, 0, 7);
        check("clr_fresh_wait", 16'(if8.chk_done), 16'h0);
        strobe8(1'b0);
        check("clr_fresh_done", 16'(if8.chk_done), 16'h1);
        check("clr_fresh_err", 16'(if8.par_err), 16'h0);

        send_bits(8'hA5, 0, 7);
        strobe8(1'b0);
        check("pre_rst_err", 16'(if8.par_err), 16'h1);
        gen(8'h01, 2'b00, 1'b0);
        send_bits(8'hFF, 0, 2);
        RST = 1'b0;
        #1;
        check("mid_rst_par_bit", 16'(if8.par_bit), 16'h0);
        check("mid_rst_par_err", 16'(if8.par_err), 16'h0);
        check("mid_rst_chk_done", 16'(if8.chk_done), 16'h0);
        tick();
        RST = 1'b1;
        tick();
        send_bits(8'h01, 0, 7);
        strobe8(1'b0);
        check("post_rst_done", 16'(if8.chk_done), 16'h1);
        check("post_rst_err", 16'(if8.par_err), 16'h0);

        if1.PAR_EN = 1'b0;
        strobe1(1'b1);
        check("w1_noen_done", 16'(if1.chk_done), 16'h1);
        check("w1_noen_err", 16'(if1.par_err), 16'h0);
        tick();
        check("w1_noen_done_low", 16'(if1.chk_done), 16'h0);
        strobe1(1'b0);
        check("w1_noen_idle_again", 16'(if1.chk_done), 16'h1);

        // width 1, odd, data 1 -> expected parity 0; sending 1 is an error
        if1.PAR_EN = 1'b1; if1.PAR_TYP = 2'b01;
        strobe1(1'b1);
        check("w1_en_wait", 16'(if1.chk_done), 16'h0);
        tick();
        strobe1(1'b1);
        check("w1_en_done", 16'(if1.chk_done), 16'h1);
        check("w1_en_err", 16'(if1.par_err), 16'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/parity_unit.md
# parity_unit

Parametrised parity generator/checker for the UART datapath, replacing the fixed 8-bit combinational parity calculator. The generator registers a parity bit for a parallel word accepted on `Data_valid` and holds it for the TX serializer. The optional checker accumulates parity bit-serially for the RX path and flags a mismatch against the received parity bit. Four parity modes: even, odd, mark, space.

## Interface
- `DATA_WIDTH`, 8, data word width in bits; legal range 1–16.
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH  parallel TX word.
- `Data_valid`  in  1  P_DATA valid; capture qualifier.
- `busy`  in  1  TX frame in progress; blocks capture.
- `PAR_EN`  in  1  parity enabled.
- `PAR_TYP`  in  2  mode: 00 even, 01 odd, 10 mark (1), 11 space (0).
- `par_bit`  out  1  registered TX parity bit.
- `ser_bit`  in  1  RX sampled data/parity bit (checker only).
- `ser_bit_valid`  in  1  one-cycle strobe qualifying `ser_bit` (checker only).
- `chk_clr`  in  1  synchronous abort/clear of the checker (checker only).
- `par_err`  out  1  registered parity-error flag (checker only).
- `chk_done`  out  1  one-cycle pulse at end of a checked word (checker only).

## Operation
- Generator: on a CLK edge with `Data_valid`=1 and `busy`=0, `par_bit` <= f(^P_DATA, PAR_TYP): even -> ^P_DATA; odd -> ~^P_DATA; mark -> 1; space -> 0.
- `Data_valid` while `busy`=1 is ignored; `par_bit` holds. `par_bit` holds in all other cycles.
- `PAR_EN` does not gate the generator; the serializer skips the parity slot.
- Checker FSM, states IDLE, ACCUM, WAIT_PAR:
  - IDLE: on `ser_bit_valid`, acc <= ser_bit, cnt <= 1, latch PAR_TYP and PAR_EN. Next state is ACCUM, or the end-of-word action below when DATA_WIDTH=1.
  - ACCUM: each `ser_bit_valid` gives acc <= acc ^ ser_bit and cnt <= cnt+1. The end-of-word action is taken when the increment makes cnt == DATA_WIDTH.
  - End of word: if latched PAR_EN=1, go to WAIT_PAR. Otherwise go to IDLE, pulse `chk_done`, and set `par_err` <= 0.
  - WAIT_PAR: on `ser_bit_valid`, compute expected = f(acc, latched PAR_TYP). Then `par_err` <= (ser_bit != expected), pulse `chk_done`, go to IDLE.
- `cnt` width is $clog2(DATA_WIDTH+1). `cnt` never exceeds DATA_WIDTH.
- `par_err` holds until the next `chk_done` or until `chk_clr`.
- `chk_clr`=1 in any state: go to IDLE, acc <= 0, cnt <= 0, `par_err` <= 0, no `chk_done`. `chk_clr` has priority over a simultaneous `ser_bit_valid`.
- PAR_TYP/PAR_EN changes mid-word do not affect the current word.

## Timing
- Reset values: `par_bit`=0, `par_err`=0, `chk_done`=0, FSM=IDLE, acc=0, cnt=0.
- Generator latency is 1 cycle: `par_bit` is valid the cycle after the accepting edge.
- Back-to-back `Data_valid` with `busy`=0 updates `par_bit` every cycle.
- `chk_done` and `par_err` update in the cycle after the parity-bit strobe.
- `chk_done` is high for exactly one cycle.
- The checker accepts at most one bit per cycle. Gaps of any length between strobes are legal.
- Reset asserted mid-word aborts immediately to the reset values above.

## Configuration
- `PARITY_CHECK_EN` defined: checker FSM, `ser_bit`, `ser_bit_valid`, `chk_clr`, `par_err` and `chk_done` are present.
- `PARITY_CHECK_EN` undefined: generator only. Checker ports are absent, and the module is a drop-in successor for TX-only use.

## Structure
- Shared package `uart_pkg`:
  - `par_typ_e` enum (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11).
  - Checker state enum.
  - Function `par_of(bit, typ)` used by both the generator and the checker.
- Sub-module `parity_chk` holds the checker FSM. It is instantiated under `PARITY_CHECK_EN`. The generator stays in the top module.

## Test plan
- Reset: RST=0 mid-activity -> `par_bit`=0, `par_err`=0, `chk_done`=0; the next word is checked from IDLE.
- Generator modes, DATA_WIDTH=8, P_DATA=8'hB3 (5 ones), `Data_valid`=1, `busy`=0:
  - even -> `par_bit`=1 next cycle
  - odd -> 0
  - mark -> 1
  - space -> 0
- Generator busy gating: P_DATA=8'h01 (even gives par_bit=1), then `busy`=1 with P_DATA=8'h03 -> `par_bit` stays 1.
- Checker pass/fail, odd parity, bits of 8'hA5 strobed LSB first with 3-cycle gaps:
  - parity bit 1 -> `chk_done` pulse, `par_err`=0
  - parity bit 0 -> `par_err`=1
- Checker abort: `chk_clr` asserted after 4 bits, same cycle as `ser_bit_valid` -> no `chk_done`, `par_err`=0; a fresh 8-bit word then checks correctly.
- PAR_EN=0 and DATA_WIDTH=1: one strobe -> `chk_done` the next cycle, `par_err`=0, FSM back in IDLE without waiting for a parity bit.
